// File: rtl/unidade_load_store.sv
// Load/store unit: one aligned access to a 64-bit data memory.
// Builds byte enables and lane-shifted data, extends loads, flags errors.
module unidade_load_store #(
  parameter int BITS           = 64,
  parameter int TIMEOUT_CICLOS = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inicia,
  input  logic            escrita,
  input  logic [2:0]      funct3,
  input  logic [BITS-1:0] endereco,
  input  logic [BITS-1:0] dado_store,
  output logic            mem_req,
  output logic            mem_we,
  output logic [BITS-1:0] mem_addr,
  output logic [7:0]      mem_be,
  output logic [BITS-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [BITS-1:0] mem_rdata,
  output logic            ocupado,
  output logic            pronto,
  output logic [BITS-1:0] dado_load,
  output logic            erro_alinhamento,
  output logic            erro_timeout
);

  localparam int CW = $clog2(TIMEOUT_CICLOS + 1);

  typedef enum logic [1:0] {
    OCIOSO,
    ACESSO,
    CONCLUI,
    ERRO
  } estado_t;

  estado_t         estado;
  logic            escrita_r;
  logic [2:0]      funct3_r;
  logic [2:0]      off_r;
  logic [CW-1:0]   cnt;

  logic [2:0]      off;
  logic [2:0]      sub;
  logic [7:0]      mascara;
  logic            erro_in;
  logic [7:0]      be_in;
  logic [BITS-1:0] wdata_in;
  logic [BITS-1:0] desloc;
  logic [BITS-1:0] ext;

  // Decode the incoming request: size mask, alignment check, lane data
  always_comb begin
    off     = endereco[2:0];
    sub     = 3'd0;
    mascara = 8'h01;
    unique case (funct3[1:0])
      2'b00: begin sub = 3'd0; mascara = 8'h01; end
      2'b01: begin sub = 3'd1; mascara = 8'h03; end
      2'b10: begin sub = 3'd3; mascara = 8'h0F; end
      2'b11: begin sub = 3'd7; mascara = 8'hFF; end
    endcase
    erro_in  = (funct3 == 3'b111)
             | (escrita & funct3[2])
             | (|(off & sub));
    be_in    = mascara << off;
    wdata_in = escrita ? (dado_store << {off, 3'b000}) : '0;
  end

  // Align the read word and sign/zero-extend it to the access size
  always_comb begin
    desloc = mem_rdata >> {off_r, 3'b000};
    ext    = desloc;
    unique case (funct3_r[1:0])
      2'b00: ext = funct3_r[2]
                 ? {{(BITS-8){1'b0}}, desloc[7:0]}
                 : {{(BITS-8){desloc[7]}}, desloc[7:0]};
      2'b01: ext = funct3_r[2]
                 ? {{(BITS-16){1'b0}}, desloc[15:0]}
                 : {{(BITS-16){desloc[15]}}, desloc[15:0]};
      2'b10: ext = funct3_r[2]
                 ? {{(BITS-32){1'b0}}, desloc[31:0]}
                 : {{(BITS-32){desloc[31]}}, desloc[31:0]};
      2'b11: ext = desloc;
    endcase
  end

  // Access FSM with registered memory-side and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      estado           <= OCIOSO;
      escrita_r        <= 1'b0;
      funct3_r         <= '0;
      off_r            <= '0;
      cnt              <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_be           <= '0;
      mem_wdata        <= '0;
      ocupado          <= 1'b0;
      pronto           <= 1'b0;
      dado_load        <= '0;
      erro_alinhamento <= 1'b0;
      erro_timeout     <= 1'b0;
    end else begin
      pronto           <= 1'b0;
      erro_alinhamento <= 1'b0;
      erro_timeout     <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (inicia) begin
            ocupado   <= 1'b1;
            escrita_r <= escrita;
            funct3_r  <= funct3;
            off_r     <= off;
            cnt       <= '0;
            if (erro_in) begin
              estado           <= ERRO;
              erro_alinhamento <= 1'b1;
            end else begin
              estado    <= ACESSO;
              mem_req   <= 1'b1;
              mem_we    <= escrita;
              mem_addr  <= {endereco[BITS-1:3], 3'b000};
              mem_be    <= be_in;
              mem_wdata <= wdata_in;
            end
          end
        end
        ACESSO: begin
          if (mem_ready) begin
            estado    <= CONCLUI;
            pronto    <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            if (!escrita_r) dado_load <= ext;
          end else if (cnt == CW'(TIMEOUT_CICLOS - 1)) begin
            estado       <= ERRO;
            erro_timeout <= 1'b1;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CONCLUI: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
        ERRO: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule
